pipe_stage_reg: RTL and testbench



---
 rtl/pipe_stage_reg.sv | 101 ++++++++++
 tb/tb_pipe_stage_reg.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, one-entry skid buffer
// and synchronous flush; carries a WIDTH-bit packed stage payload.
//
// state | meaning
// EMPTY | no payload held, out_valid low
// FULL  | main holds a payload, skid empty
// SKID  | main and skid both hold payloads, in_ready low
module pipe_stage_reg #(
  parameter int unsigned          WIDTH     = 32,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  // bit 0 is main_valid, bit 1 is skid_valid; 2'b10 is unreachable
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    SKID  = 2'b11
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] main_data, skid_data;
  logic             main_valid, skid_valid;
  logic             acc, take;
  logic             load_main, load_skid, main_from_skid;

  assign main_valid = state[0];
  assign skid_valid = state[1];
  assign in_ready   = !skid_valid && !rst;
  assign out_valid  = main_valid;
  assign out_data   = main_data;
  assign occupancy  = {1'b0, main_valid} + {1'b0, skid_valid};
  assign acc        = in_valid && in_ready;
  assign take       = out_valid && out_ready;

  always_comb begin
    state_nx       = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      EMPTY: begin
        if (acc) begin
          load_main = 1'b1;
          state_nx  = FULL;
        end
      end
      FULL: begin
        if (acc && take) begin
          load_main = 1'b1;
        end else if (acc) begin
          load_skid = 1'b1;
          state_nx  = SKID;
        end else if (take) begin
          state_nx  = EMPTY;
        end
      end
      SKID: begin
        if (take) begin
          main_from_skid = 1'b1;
          state_nx       = FULL;
        end
      end
      default: state_nx = EMPTY;
    endcase
    // a squash empties the stage and leaves the data registers untouched
    if (flush) begin
      state_nx       = EMPTY;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      main_data <= RESET_VAL;
      skid_data <= RESET_VAL;
    end else begin
      state <= state_nx;
      if (load_main)
        main_data <= in_data;
      else if (main_from_skid)
        main_data <= skid_data;
      if (load_skid)
        skid_data <= in_data;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenario tasks plus a
// queue-based reference model checked on every falling edge.
module tb_pipe_stage_reg;

  localparam int          W  = 32;
  localparam logic [W-1:0] RV = 32'h5A5A_0000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] q[$];

  pipe_stage_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // reference model: queue contents are the payloads the stage must hold
  always @(negedge clk) begin
    int  sz;
    bit  m_acc, m_take;
    if (rst) begin
      checks++;
      if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL mon_rst: out_valid=%b occupancy=%0d in_ready=%b, required 0/0/0",
                 out_valid, occupancy, in_ready);
      end
      q.delete();
    end else begin
      sz = q.size();
      checks++;
      if (occupancy !== 2'(sz)) begin
        errors++;
        $display("FAIL mon_occupancy: got %0d required %0d", occupancy, sz);
      end
      checks++;
      if (out_valid !== (sz > 0) || in_ready !== (sz < 2)) begin
        errors++;
        $display("FAIL mon_handshake: out_valid=%b in_ready=%b required %b/%b",
                 out_valid, in_ready, sz > 0, sz < 2);
      end
      if (sz > 0) begin
        checks++;
        if (out_data !== q[0]) begin
          errors++;
          $display("FAIL mon_data: got %h required %h", out_data, q[0]);
        end
      end
      m_take = (sz > 0) && out_ready;
      m_acc  = in_valid && (sz < 2);
      if (m_take) void'(q.pop_front());
      if (flush) q.delete();
      else if (m_acc) q.push_back(in_data);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== RV || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: ov=%b ir=%b od=%h occ=%0d required 0/0/%h/0",
               out_valid, in_ready, out_data, occupancy, RV);
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_streaming;
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = W'(i);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== W'(i) || occupancy !== 2'd1 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_%0d: ov=%b od=%h occ=%0d ir=%b required 1/%h/1/1",
                 i, out_valid, out_data, occupancy, in_ready, W'(i));
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_drain: occ=%0d ov=%b required 0/0", occupancy, out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic load_ab;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA;
    tick();
    in_data = 32'hB;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_skid;
    load_ab();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'hA) begin
        errors++;
        $display("FAIL skid_stall_%0d: occ=%0d ir=%b ov=%b od=%h required 2/0/1/0000000a",
                 i, occupancy, in_ready, out_valid, out_data);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_data !== 32'hB || out_valid !== 1'b1 || in_ready !== 1'b1 || occupancy !== 2'd1) begin
      errors++;
      $display("FAIL skid_release: od=%h ov=%b ir=%b occ=%0d required 0000000b/1/1/1",
               out_data, out_valid, in_ready, occupancy);
    end
    tick();
    checks++;
    if (occupancy !== 2'd0) begin
      errors++;
      $display("FAIL skid_drain: occ=%0d required 0", occupancy);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_flush;
    load_ab();
    flush = 1'b1; in_valid = 1'b1; in_data = 32'hC;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_skid: occ=%0d ov=%b ir=%b required 0/0/1", occupancy, out_valid, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_no_c: out_valid=%b od=%h required out_valid 0", out_valid, out_data);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_alternating;
    int  sent = 0, rcvd = 0;
    bit  a, t;
    for (int cyc = 0; cyc < 200 && rcvd < 16; cyc++) begin
      out_ready = (cyc % 2 == 0);
      in_valid  = (sent < 16);
      in_data   = W'(32'h10 + sent);
      a = in_valid && in_ready;
      t = out_valid && out_ready;
      if (t) begin
        checks++;
        if (out_data !== W'(32'h10 + rcvd)) begin
          errors++;
          $display("FAIL alt_order_%0d: got %h required %h", rcvd, out_data, W'(32'h10 + rcvd));
        end
        rcvd++;
      end
      tick();
      if (a) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (rcvd != 16) begin
      errors++;
      $display("FAIL alt_count: received %0d required 16 within cycle budget", rcvd);
    end
  endtask

  task automatic test_async_reset;
    load_ab();
    #1 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b0 || out_data !== RV) begin
      errors++;
      $display("FAIL async_rst: ov=%b occ=%0d ir=%b od=%h required 0/0/0/%h",
               out_valid, occupancy, in_ready, out_data, RV);
    end
    tick();
    rst = 1'b0; in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h55) begin
      errors++;
      $display("FAIL async_first_acc: ov=%b od=%h required 1/00000055", out_valid, out_data);
    end
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_skid();
    test_flush();
    test_alternating();
    tick();
    test_async_reset();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
